// File: rtl/data_mem_arb_if.sv
// Requester-side bus of data_mem_arb: capture stream and host access port.
// master = measurement core / host side, slave = the arbiter.
interface data_mem_arb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
);
  logic                  cap_valid;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_ready;
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_gnt;
  logic                  host_rvalid;
  logic [DATA_WIDTH-1:0] host_rdata;

  modport master (
    output cap_valid, cap_data, host_req, host_we, host_addr, host_wdata,
    input  cap_ready, host_gnt, host_rvalid, host_rdata
  );

  modport slave (
    input  cap_valid, cap_data, host_req, host_we, host_addr, host_wdata,
    output cap_ready, host_gnt, host_rvalid, host_rdata
  );
endinterface

// File: rtl/data_mem_arb.sv
// Single-port measurement memory arbiter: capture ring buffer vs host access.
// Define DATA_MEM_ARB_HOST_PRIO_EN for fixed host priority instead of round-robin.
module data_mem_arb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_arb_if.slave         bus,
  input  logic                  buf_clr,
  input  logic                  ovf_clr,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH:0]   fill_cnt,
  output logic                  ovf
);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   FILL_FULL = (ADDR_WIDTH + 1)'(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} state_t;

  state_t                state;
  logic                  rd_oor;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic cap_req, host_req_ok, host_in_range;
  logic cap_gnt, host_gnt_w, ovf_set;

`ifndef DATA_MEM_ARB_HOST_PRIO_EN
  logic last_cap;
`endif

  always_comb begin
    cap_req       = bus.cap_valid & ~buf_clr & ~rst;
    host_req_ok   = bus.host_req & (state == IDLE) & ~rst;
    host_in_range = {1'b0, bus.host_addr} < FILL_FULL;
`ifdef DATA_MEM_ARB_HOST_PRIO_EN
    host_gnt_w = host_req_ok;
    cap_gnt    = cap_req & ~host_req_ok;
`else
    // On contention, the side granted last yields.
    cap_gnt    = cap_req & (~host_req_ok | ~last_cap);
    host_gnt_w = host_req_ok & ~cap_gnt;
`endif
    mem_wr_en   = cap_gnt | (host_gnt_w & bus.host_we & host_in_range);
    mem_rd_en   = host_gnt_w & ~bus.host_we & host_in_range;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (cap_gnt) begin
      mem_wr_addr = wr_ptr;
      mem_wr_data = bus.cap_data;
    end else if (mem_wr_en) begin
      mem_wr_addr = bus.host_addr;
      mem_wr_data = bus.host_wdata;
    end
    mem_rd_addr = mem_rd_en ? bus.host_addr : '0;
    ovf_set     = cap_gnt & (fill_cnt == FILL_FULL);
  end

  assign bus.cap_ready   = cap_gnt;
  assign bus.host_gnt    = host_gnt_w;
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = rdata_q;

  // Ring pointer, fill level and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      ovf      <= 1'b0;
    end else if (buf_clr) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (cap_gnt) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        if (fill_cnt != FILL_FULL)
          fill_cnt <= fill_cnt + 1'b1;
      end
      if (ovf_set)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

`ifndef DATA_MEM_ARB_HOST_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst)
      last_cap <= 1'b0;
    else if (cap_gnt | host_gnt_w)
      last_cap <= cap_gnt;
  end
`endif

  // Host read sequencing; host grants are locked out outside IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_oor   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          rvalid_q <= 1'b0;
          if (host_gnt_w & ~bus.host_we) begin
            rd_oor <= ~host_in_range;
            state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rdata_q  <= rd_oor ? '0 : mem_rd_data;
          rvalid_q <= 1'b1;
          state    <= RD_RESP;
        end
        RD_RESP: begin
          rvalid_q <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          rvalid_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arb.sv
// Self-checking bench for data_mem_arb: randomized host/capture traffic vs a ring/shadow-memory model.
module tb_data_mem_arb;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int MS = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          buf_clr = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          mem_wr_en, mem_rd_en, ovf;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr, wr_ptr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic [AW:0]   fill_cnt;

  data_mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst(rst), .bus(bus), .buf_clr(buf_clr), .ovf_clr(ovf_clr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .wr_ptr(wr_ptr), .fill_cnt(fill_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Memory instance the arbiter fronts: 1-cycle read latency.
  logic [DW-1:0] tmem [0:31];
  always @(posedge clk) begin
    if (mem_wr_en) tmem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= tmem[mem_rd_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: samples accepted since last clear, sticky overflow, expected memory image.
  int            m_total = 0;
  bit            m_ovf = 0;
  bit            last_was_cap = 0;
  logic [DW-1:0] shadow [0:MS-1];

  function automatic logic [AW-1:0] e_ptr();
    return AW'(m_total % MS);
  endfunction

  function automatic logic [AW:0] e_fill();
    return (m_total > MS) ? (AW + 1)'(MS) : (AW + 1)'(m_total);
  endfunction

  task automatic m_accept(input logic [DW-1:0] d);
    shadow[m_total % MS] = d;
    if (m_total >= MS) m_ovf = 1;
    m_total++;
  endtask

  task automatic m_clear();
    m_total = 0;
    m_ovf = 0;
  endtask

  typedef struct packed {
    logic          to;
    logic          wen;
    logic          ren;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic          lock;
    logic [2:0]    rv;
    logic [DW-1:0] rd;
  } obs_t;

  // Runs one host transaction and records what the DUT did; reads hold req through the lock window.
  task automatic host_xact(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, output obs_t o);
    bit got = 0;
    o = '0;
    o.to = 1'b1;
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = wd;
    for (int k = 0; k < 40 && !got; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (bus.host_gnt === 1'b1) got = 1;
    end
    if (!got) begin
      bus.host_req = 1'b0;
      return;
    end
    o.to = 1'b0; o.wen = mem_wr_en; o.ren = mem_rd_en;
    o.wa = mem_wr_addr; o.wd = mem_wr_data; o.ra = mem_rd_addr;
    if (we) begin
      @(negedge clk);
      bus.host_req = 1'b0;
      return;
    end
    @(negedge clk); #1;
    o.lock = bus.host_gnt; o.rv[0] = bus.host_rvalid;
    @(negedge clk); #1;
    o.lock = o.lock | bus.host_gnt; o.rv[1] = bus.host_rvalid; o.rd = bus.host_rdata;
    @(negedge clk);
    bus.host_req = 1'b0;
    #1;
    o.rv[2] = bus.host_rvalid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cap_valid = 1'b1; bus.cap_data = 16'h1234;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 5'd3; bus.host_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.cap_ready, bus.host_gnt, mem_wr_en, mem_rd_en} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_grants: got %b expected 0000", {bus.cap_ready, bus.host_gnt, mem_wr_en, mem_rd_en});
    end
    n_cmp++;
    if ({wr_ptr, fill_cnt, ovf, bus.host_rvalid, bus.host_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected 0", {wr_ptr, fill_cnt, ovf, bus.host_rvalid, bus.host_rdata});
    end
    @(negedge clk);
    rst = 1'b0; bus.cap_valid = 1'b0; bus.host_req = 1'b0;
    m_clear();
    last_was_cap = 0;
  endtask

  task automatic test_capture_fill();
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({wr_ptr, fill_cnt, ovf} !== {e_ptr(), e_fill(), m_ovf}) begin
        n_err++;
        $display("FAIL ring[%0d]: got %h expected %h", i, {wr_ptr, fill_cnt, ovf}, {e_ptr(), e_fill(), m_ovf});
      end
      bus.cap_valid = 1'b1; bus.cap_data = DW'(i);
      #1;
      n_cmp++;
      if ({bus.cap_ready, mem_wr_en, mem_rd_en, mem_wr_addr, mem_wr_data} !== {1'b1, 1'b1, 1'b0, e_ptr(), DW'(i)}) begin
        n_err++;
        $display("FAIL cap_write[%0d]: got %h expected %h", i,
                 {bus.cap_ready, mem_wr_en, mem_rd_en, mem_wr_addr, mem_wr_data}, {1'b1, 1'b1, 1'b0, e_ptr(), DW'(i)});
      end
      m_accept(DW'(i));
    end
    @(negedge clk);
    bus.cap_valid = 1'b0;
    n_cmp++;
    if ({wr_ptr, fill_cnt, ovf} !== {5'd2, 6'd30, 1'b1}) begin
      n_err++;
      $display("FAIL ring_after_32: got %h expected %h", {wr_ptr, fill_cnt, ovf}, {5'd2, 6'd30, 1'b1});
    end
  endtask

  task automatic test_host_rw();
    obs_t o;
    host_xact(1'b1, 5'd5, 16'hBEEF, o);
    shadow[5] = 16'hBEEF;
    n_cmp++;
    if ({o.to, o.wen, o.ren, o.wa, o.wd} !== {1'b0, 1'b1, 1'b0, 5'd5, 16'hBEEF}) begin
      n_err++;
      $display("FAIL host_write5: got %h expected %h", {o.to, o.wen, o.ren, o.wa, o.wd}, {1'b0, 1'b1, 1'b0, 5'd5, 16'hBEEF});
    end
    host_xact(1'b0, 5'd5, '0, o);
    n_cmp++;
    if ({o.to, o.wen, o.ren, o.ra, o.lock, o.rv, o.rd} !== {1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 3'b010, 16'hBEEF}) begin
      n_err++;
      $display("FAIL host_read5: got %h expected %h", {o.to, o.wen, o.ren, o.ra, o.lock, o.rv, o.rd},
               {1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 3'b010, 16'hBEEF});
    end
  endtask

  task automatic test_host_random();
    obs_t          o;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, exp_rd;
    logic          we, inr;
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 1));
      wd = DW'($urandom);
      inr = (a < MS);
      exp_rd = inr ? shadow[a] : '0;
      host_xact(we, a, wd, o);
      n_cmp++;
      if (we) begin
        if (o.to !== 1'b0 || o.wen !== inr || o.ren !== 1'b0 || (inr && {o.wa, o.wd} !== {a, wd})) begin
          n_err++;
          $display("FAIL rand_write[%0d] @%0d: got %h expected en=%b %h", i, a, {o.to, o.wen, o.ren, o.wa, o.wd}, inr, {a, wd});
        end
        if (inr) shadow[a] = wd;
      end else begin
        if (o.to !== 1'b0 || o.wen !== 1'b0 || o.ren !== inr || (inr && o.ra !== a) ||
            o.lock !== 1'b0 || o.rv !== 3'b010 || o.rd !== exp_rd) begin
          n_err++;
          $display("FAIL rand_read[%0d] @%0d: got %h expected en=%b rv=010 data=%h", i, a,
                   {o.to, o.wen, o.ren, o.ra, o.lock, o.rv, o.rd}, inr, exp_rd);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    obs_t o;
    host_xact(1'b0, 5'd31, '0, o);
    n_cmp++;
    if ({o.to, o.wen, o.ren, o.rv, o.rd} !== {1'b0, 1'b0, 1'b0, 3'b010, 16'h0000}) begin
      n_err++;
      $display("FAIL oor_read31: got %h expected %h", {o.to, o.wen, o.ren, o.rv, o.rd}, {1'b0, 1'b0, 1'b0, 3'b010, 16'h0000});
    end
    host_xact(1'b1, 5'd30, 16'h5A5A, o);
    n_cmp++;
    if ({o.to, o.wen, o.ren} !== 3'b000) begin
      n_err++;
      $display("FAIL oor_write30: got %b expected 000", {o.to, o.wen, o.ren});
    end
  endtask

  task automatic test_contention();
    logic [DW-1:0] cd, hd;
    logic [AW-1:0] ha;
    bit            exp_cap;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_clear();
    last_was_cap = 0;
    cd = DW'($urandom); hd = DW'($urandom); ha = AW'($urandom_range(0, MS - 1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.cap_valid = 1'b1; bus.cap_data = cd;
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = ha; bus.host_wdata = hd;
      #1;
`ifdef DATA_MEM_ARB_HOST_PRIO_EN
      exp_cap = 0;
`else
      exp_cap = !last_was_cap;
`endif
      n_cmp++;
      if ({bus.cap_ready, bus.host_gnt, mem_wr_en, mem_rd_en, mem_wr_addr, mem_wr_data} !==
          {exp_cap, !exp_cap, 1'b1, 1'b0, exp_cap ? e_ptr() : ha, exp_cap ? cd : hd}) begin
        n_err++;
        $display("FAIL contend[%0d]: got %h expected %h", i,
                 {bus.cap_ready, bus.host_gnt, mem_wr_en, mem_rd_en, mem_wr_addr, mem_wr_data},
                 {exp_cap, !exp_cap, 1'b1, 1'b0, exp_cap ? e_ptr() : ha, exp_cap ? cd : hd});
      end
      if (exp_cap) begin
        m_accept(cd);
        cd = DW'($urandom);
      end else begin
        shadow[ha] = hd;
        hd = DW'($urandom);
        ha = AW'($urandom_range(0, MS - 1));
      end
      last_was_cap = exp_cap;
    end
    @(negedge clk);
    bus.cap_valid = 1'b0; bus.host_req = 1'b0;
    n_cmp++;
    if ({wr_ptr, fill_cnt, ovf} !== {e_ptr(), e_fill(), m_ovf}) begin
      n_err++;
      $display("FAIL contend_ring: got %h expected %h", {wr_ptr, fill_cnt, ovf}, {e_ptr(), e_fill(), m_ovf});
    end
  endtask

  task automatic test_clears();
    @(negedge clk);
    buf_clr = 1'b1; bus.cap_valid = 1'b1; bus.cap_data = 16'hDEAD;
    #1;
    n_cmp++;
    if ({bus.cap_ready, mem_wr_en} !== 2'b00) begin
      n_err++;
      $display("FAIL bufclr_block1: got %b expected 00", {bus.cap_ready, mem_wr_en});
    end
    m_clear();
    @(negedge clk);
    buf_clr = 1'b0; bus.cap_valid = 1'b0;
    n_cmp++;
    if ({wr_ptr, fill_cnt, ovf} !== '0) begin
      n_err++;
      $display("FAIL bufclr_state1: got %h expected 0", {wr_ptr, fill_cnt, ovf});
    end
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      bus.cap_valid = 1'b1; bus.cap_data = DW'($urandom);
      ovf_clr = (i == 30);
      #1;
      n_cmp++;
      if (bus.cap_ready !== 1'b1) begin
        n_err++;
        $display("FAIL refill[%0d]: cap_ready got %b expected 1", i, bus.cap_ready);
      end
      m_accept(bus.cap_data);
    end
    @(negedge clk);
    bus.cap_valid = 1'b0; ovf_clr = 1'b0;
    n_cmp++;
    if ({wr_ptr, fill_cnt, ovf} !== {e_ptr(), e_fill(), 1'b1}) begin
      n_err++;
      $display("FAIL ovf_set_beats_clr: got %h expected %h", {wr_ptr, fill_cnt, ovf}, {e_ptr(), e_fill(), 1'b1});
    end
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    m_ovf = 0;
    n_cmp++;
    if (ovf !== m_ovf) begin
      n_err++;
      $display("FAIL ovf_clr: got %b expected %b", ovf, m_ovf);
    end
    @(negedge clk);
    bus.cap_valid = 1'b1; bus.cap_data = DW'($urandom);
    m_accept(bus.cap_data);
    @(negedge clk);
    buf_clr = 1'b1;
    #1;
    n_cmp++;
    if ({ovf, bus.cap_ready, mem_wr_en} !== 3'b100) begin
      n_err++;
      $display("FAIL bufclr_block2: got %b expected 100", {ovf, bus.cap_ready, mem_wr_en});
    end
    m_clear();
    @(negedge clk);
    buf_clr = 1'b0; bus.cap_valid = 1'b0;
    n_cmp++;
    if ({wr_ptr, fill_cnt, ovf} !== {e_ptr(), e_fill(), m_ovf}) begin
      n_err++;
      $display("FAIL bufclr_state2: got %h expected %h", {wr_ptr, fill_cnt, ovf}, {e_ptr(), e_fill(), m_ovf});
    end
  endtask

  task automatic test_rst_mid_read();
    obs_t          o;
    logic [AW-1:0] a;
    bit            saw_rv = 0;
    a = AW'($urandom_range(0, MS - 1));
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = a;
    #1;
    n_cmp++;
    if ({bus.host_gnt, mem_rd_en, mem_rd_addr} !== {1'b1, 1'b1, a}) begin
      n_err++;
      $display("FAIL midrd_grant: got %h expected %h", {bus.host_gnt, mem_rd_en, mem_rd_addr}, {1'b1, 1'b1, a});
    end
    @(negedge clk);
    bus.host_req = 1'b0; rst = 1'b1;
    #1;
    saw_rv = bus.host_rvalid;
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    last_was_cap = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      saw_rv = saw_rv | bus.host_rvalid;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_rv !== 1'b0) begin
      n_err++;
      $display("FAIL midrd_no_rvalid: got %b expected 0", saw_rv);
    end
    host_xact(1'b0, a, '0, o);
    n_cmp++;
    if ({o.to, o.ren, o.ra, o.lock, o.rv, o.rd} !== {1'b0, 1'b1, a, 1'b0, 3'b010, shadow[a]}) begin
      n_err++;
      $display("FAIL midrd_retry: got %h expected %h", {o.to, o.ren, o.ra, o.lock, o.rv, o.rd},
               {1'b0, 1'b1, a, 1'b0, 3'b010, shadow[a]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cap_valid = 1'b0; bus.cap_data = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    test_reset();
    test_capture_fill();
    test_host_rw();
    test_host_random();
    test_out_of_range();
    test_contention();
    test_clears();
    test_rst_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
